smile_window_counter: RTL and testbench
=======================================

Name: smile_window_counter

Overview:
- Sits directly downstream of the serial "01" sequence detector and consumes its smile output.
- Counts detection events over a programmable window of clock cycles.
- At each window close, emits the window count to a consumer over a valid/ready handshake.
- Flags reports lost to consumer back-pressure with a sticky overrun bit.

Parameters:
- CNT_W, 8, width of event accumulator and reported count.
- WIN_W, 16, width of window-length input and internal window down-counter.

Ports:
- clk_in  input  1  clock.
- rst_in  input  1  reset; asynchronous, active-high. Clock is clk_in.
- smile_in  input  1  detector output; high for one cycle per detected "01".
- enable_in  input  1  counting enable; low = idle, partial window discarded.
- win_len_in  input  WIN_W  window length in cycles; sampled only at window start.
- report_data_out  output  CNT_W  event count of the most recently closed, unaccepted window.
- report_valid_out  output  1  report_data_out holds an unaccepted report.
- report_ready_in  input  1  consumer accepts the report when high together with valid.
- report_overrun_out  output  1  sticky: a window closed while a report was pending and was dropped.
- overrun_clr_in  input  1  clears report_overrun_out.

Behaviour:
- Reset values (asynchronous): report_data_out=0, report_valid_out=0, report_overrun_out=0; internally smile_q=0, accumulator=0, window counter=0, state=IDLE.
- Event detection:
  - event = smile_in & ~smile_q, where smile_q is smile_in registered.
  - Rising-edge counting: a smile_in held high for k cycles counts once.
- State machine, two states:
  - IDLE: accumulator held at 0. If enable_in=1, load window counter with win_len_in (value 0 treated as 1) and go to COUNT. An event in that same cycle is not counted.
  - COUNT: each cycle, accumulator += event, saturating at 2^CNT_W-1. Window counter decrements each cycle.
  - Terminal cycle: window counter == 1. The closing count, including that cycle's event, is offered to the report register. The accumulator restarts at 0 and the window counter reloads from the current win_len_in (0 treated as 1). Windows are back-to-back with no gap cycles.
  - COUNT with enable_in=0: go to IDLE. Accumulator and window counter clear; the partial window produces no report.
  - enable_in low is checked before the terminal condition: if enable_in=0 on the terminal cycle, no report is generated.
- Window timing: window length N spans exactly N clock cycles of event samples. The report becomes visible (valid=1) on the cycle after the terminal cycle.
- Report handshake:
  - Transfer occurs on any cycle with report_valid_out & report_ready_in.
  - report_data_out is stable while valid is high and unaccepted.
  - Window close with no pending report, or with a pending report accepted in the same cycle: load the new count, valid=1.
  - Window close with a pending report not accepted: keep the old report (oldest wins), drop the new count, set report_overrun_out=1.
  - Transfer with no window close: valid=0 next cycle; data holds its last value.
- Overrun flag: cleared by overrun_clr_in=1. If a set and a clear occur in the same cycle, set wins.
- Pending report survives enable_in dropping; only reset or a transfer removes it.
- win_len_in changes mid-window have no effect until the next window load.
- Reset mid-window: all state returns to reset values immediately; no report is emitted.

Test Plan:
- Basic window: win_len=10, enable held high, ready=1, three 1-cycle smile pulses in cycles 2, 5, 8 of the window -> report_data_out=3 with valid=1 for exactly one cycle, on the cycle after the 10th window cycle.
- Edge counting and saturation: CNT_W=4, win_len=100, 20 separate pulses plus one 5-cycle-high pulse -> report_data_out=15 (saturated); with 6 pulses where one is 5 cycles high -> report=6.
- Back-pressure/overrun: win_len=4, ready=0, windows with 1 then 2 events -> report_data_out stays 1, overrun=1; then ready=1 -> transfer of 1, and the next window's count appears. overrun_clr_in pulse -> overrun=0.
- Simultaneous accept and close: ready asserted exactly on a terminal cycle with a pending report -> old report transfers, new count loaded, valid stays 1, overrun stays 0.
- Enable drop: enable_in low for one cycle mid-window after 2 events -> no report; the next window restarts with count 0 and its full length from the current win_len_in. win_len=0 -> a report every cycle.
- Async reset: assert rst_in mid-window with a pending report -> all outputs 0 immediately without a clock edge; after release with enable=1, the first report reflects only post-reset events.

Source files
------------

// File: rtl/smile_window_counter.sv
// Counts rising edges of the "01" detector's smile output over programmable
// back-to-back windows and hands each window count to a valid/ready consumer.
module smile_window_counter #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             smile_in,
  input  logic             enable_in,
  input  logic [WIN_W-1:0] win_len_in,
  output logic [CNT_W-1:0] report_data_out,
  output logic             report_valid_out,
  input  logic             report_ready_in,
  output logic             report_overrun_out,
  input  logic             overrun_clr_in
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             smile_q;
  logic [CNT_W-1:0] acc_q, acc_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             evt;
  logic             close;
  logic [CNT_W-1:0] acc_inc;
  logic [WIN_W-1:0] win_load;

  assign evt      = smile_in & ~smile_q;
  assign acc_inc  = (evt && (acc_q != '1)) ? acc_q + CNT_W'(1) : acc_q;
  assign win_load = (win_len_in == '0) ? WIN_W'(1) : win_len_in;
  // Enable low has priority over the terminal cycle, so close requires enable.
  assign close    = (state_q == ST_COUNT) && enable_in && (win_q == WIN_W'(1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    win_d   = win_q;
    case (state_q)
      ST_IDLE: begin
        acc_d = '0;
        if (enable_in) begin
          win_d   = win_load;
          state_d = ST_COUNT;
        end
      end
      default: begin
        if (!enable_in) begin
          acc_d   = '0;
          win_d   = '0;
          state_d = ST_IDLE;
        end else if (close) begin
          acc_d = '0;
          win_d = win_load;
        end else begin
          acc_d = acc_inc;
          win_d = win_q - WIN_W'(1);
        end
      end
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (overrun_clr_in) ovr_d = 1'b0;
    if (close) begin
      if (!valid_q || report_ready_in) begin
        data_d  = acc_inc;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && report_ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      smile_q <= 1'b0;
      acc_q   <= '0;
      win_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      smile_q <= smile_in;
      acc_q   <= acc_d;
      win_q   <= win_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign report_data_out    = data_q;
  assign report_valid_out   = valid_q;
  assign report_overrun_out = ovr_q;

endmodule

// File: tb/tb_smile_window_counter.sv
// Bench for smile_window_counter: directed scenarios plus a randomized run
// checked against a window-level behavioural model.
module tb_smile_window_counter;

  localparam int CNT_W = 4;
  localparam int WIN_W = 16;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             smile = 1'b0;
  logic             enable = 1'b0;
  logic [WIN_W-1:0] win_len = '0;
  logic             ready = 1'b0;
  logic             clr = 1'b0;
  logic [CNT_W-1:0] report_data_out;
  logic             report_valid_out;
  logic             report_overrun_out;

  int checks = 0;
  int passed = 0;

  // Model state: whether a window is open, cycles left in it, events so far,
  // plus the report register contents.
  bit m_active;
  int m_left;
  int m_cnt;
  bit m_prev;
  int m_data;
  bit m_valid;
  bit m_ovr;

  smile_window_counter #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .smile_in          (smile),
    .enable_in         (enable),
    .win_len_in        (win_len),
    .report_data_out   (report_data_out),
    .report_valid_out  (report_valid_out),
    .report_ready_in   (ready),
    .report_overrun_out(report_overrun_out),
    .overrun_clr_in    (clr)
  );

  initial forever #5 clk = ~clk;

  task automatic m_reset();
    m_active = 0; m_left = 0; m_cnt = 0; m_prev = 0;
    m_data = 0; m_valid = 0; m_ovr = 0;
  endtask

  // Advance one clock: apply the rules to the inputs present at this edge.
  task automatic tick();
    int ev, nc, wl;
    bit cl, set_o;
    ev = (smile && !m_prev) ? 1 : 0;
    wl = (win_len == 0) ? 1 : int'(win_len);
    cl = 0;
    nc = 0;
    if (!m_active) begin
      if (enable) begin m_active = 1; m_left = wl; m_cnt = 0; end
    end else if (!enable) begin
      m_active = 0; m_left = 0; m_cnt = 0;
    end else begin
      nc = (m_cnt + ev > MAXC) ? MAXC : m_cnt + ev;
      if (m_left == 1) begin cl = 1; m_cnt = 0; m_left = wl; end
      else begin m_cnt = nc; m_left = m_left - 1; end
    end
    set_o = cl && m_valid && !ready;
    if (cl && !set_o) begin m_data = nc; m_valid = 1; end
    else if (!cl && m_valid && ready) m_valid = 0;
    if (set_o) m_ovr = 1;
    else if (clr) m_ovr = 0;
    m_prev = smile;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; smile = 0; enable = 0; ready = 0; clr = 0; win_len = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (report_data_out !== '0) $display("FAIL reset_data: got %0d expected 0", report_data_out); else passed++;
    checks++; if (report_valid_out !== 1'b0) $display("FAIL reset_valid: got %b expected 0", report_valid_out); else passed++;
    checks++; if (report_overrun_out !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", report_overrun_out); else passed++;
    rst = 0;
    m_reset();
    tick();
    checks++; if (report_valid_out !== 1'b0) $display("FAIL idle_valid: got %b expected 0", report_valid_out); else passed++;
  endtask

  task automatic test_basic();
    smile = 0; ready = 1; win_len = 16'd10; enable = 1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      smile = (c == 2 || c == 5 || c == 8);
      tick();
      if (c < 10) begin
        checks++; if (report_valid_out !== 1'b0) $display("FAIL basic_early_valid c=%0d: got %b expected 0", c, report_valid_out); else passed++;
      end
    end
    checks++; if (report_valid_out !== 1'b1) $display("FAIL basic_valid: got %b expected 1", report_valid_out); else passed++;
    checks++; if (report_data_out !== 4'd3) $display("FAIL basic_data: got %0d expected 3", report_data_out); else passed++;
    smile = 0;
    tick();
    checks++; if (report_valid_out !== 1'b0) $display("FAIL basic_one_cycle: got %b expected 0", report_valid_out); else passed++;
    enable = 0;
    tick();
  endtask

  task automatic test_saturation();
    smile = 0; ready = 1; win_len = 16'd100; enable = 1;
    tick();
    for (int i = 0; i < 100; i++) begin
      smile = (i < 40 && i % 2 == 0) || (i >= 50 && i < 55);
      tick();
    end
    checks++; if (report_data_out !== 4'd15 || report_valid_out !== 1'b1)
      $display("FAIL sat_data: got %0d/%b expected 15/1", report_data_out, report_valid_out); else passed++;
    for (int i = 0; i < 100; i++) begin
      smile = (i < 10 && i % 2 == 0) || (i >= 20 && i < 25);
      tick();
    end
    checks++; if (report_data_out !== 4'd6 || report_valid_out !== 1'b1)
      $display("FAIL held_pulse_data: got %0d/%b expected 6/1", report_data_out, report_valid_out); else passed++;
    smile = 0; enable = 0;
    tick();
  endtask

  task automatic test_overrun();
    smile = 0; ready = 0; win_len = 16'd4; enable = 1;
    tick();
    for (int i = 0; i < 4; i++) begin smile = (i == 1); tick(); end
    checks++; if (report_data_out !== 4'd1 || report_valid_out !== 1'b1)
      $display("FAIL ovr_first: got %0d/%b expected 1/1", report_data_out, report_valid_out); else passed++;
    for (int i = 0; i < 4; i++) begin smile = (i == 0 || i == 2); tick(); end
    checks++; if (report_data_out !== 4'd1) $display("FAIL ovr_oldest_kept: got %0d expected 1", report_data_out); else passed++;
    checks++; if (report_overrun_out !== 1'b1) $display("FAIL ovr_set: got %b expected 1", report_overrun_out); else passed++;
    ready = 1;
    for (int i = 0; i < 4; i++) begin
      smile = (i == 0 || i == 2);
      tick();
      if (i == 0) begin
        checks++; if (report_valid_out !== 1'b0 || report_data_out !== 4'd1)
          $display("FAIL ovr_transfer: got %0d/%b expected 1/0", report_data_out, report_valid_out); else passed++;
      end
    end
    checks++; if (report_data_out !== 4'd2 || report_valid_out !== 1'b1)
      $display("FAIL ovr_next: got %0d/%b expected 2/1", report_data_out, report_valid_out); else passed++;
    checks++; if (report_overrun_out !== 1'b1) $display("FAIL ovr_sticky: got %b expected 1", report_overrun_out); else passed++;
    smile = 0; enable = 0; clr = 1;
    tick();
    clr = 0;
    checks++; if (report_overrun_out !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", report_overrun_out); else passed++;
  endtask

  task automatic test_back_to_back();
    smile = 0; ready = 0; win_len = 16'd3; enable = 1;
    tick();
    for (int i = 0; i < 3; i++) begin smile = (i == 0); tick(); end
    checks++; if (report_data_out !== 4'd1 || report_valid_out !== 1'b1)
      $display("FAIL b2b_pending: got %0d/%b expected 1/1", report_data_out, report_valid_out); else passed++;
    for (int i = 0; i < 3; i++) begin
      smile = (i == 0 || i == 2);
      ready = (i == 2);
      tick();
    end
    checks++; if (report_data_out !== 4'd2 || report_valid_out !== 1'b1)
      $display("FAIL b2b_reload: got %0d/%b expected 2/1", report_data_out, report_valid_out); else passed++;
    checks++; if (report_overrun_out !== 1'b0) $display("FAIL b2b_no_overrun: got %b expected 0", report_overrun_out); else passed++;
    smile = 0; enable = 0;
    tick();
    checks++; if (report_valid_out !== 1'b0) $display("FAIL b2b_drain: got %b expected 0", report_valid_out); else passed++;
  endtask

  task automatic test_enable_drop();
    smile = 0; ready = 1; win_len = 16'd8; enable = 1;
    tick();
    for (int i = 0; i < 4; i++) begin smile = (i == 0 || i == 2); tick(); end
    enable = 0; smile = 0;
    tick();
    win_len = 16'd6; enable = 1;
    tick();
    for (int i = 0; i < 6; i++) begin
      smile = (i == 1);
      win_len = 16'd9;
      tick();
      if (i < 5) begin
        checks++; if (report_valid_out !== 1'b0) $display("FAIL drop_no_report i=%0d: got %b expected 0", i, report_valid_out); else passed++;
      end
    end
    checks++; if (report_data_out !== 4'd1 || report_valid_out !== 1'b1)
      $display("FAIL drop_restart: got %0d/%b expected 1/1", report_data_out, report_valid_out); else passed++;
    smile = 0; enable = 0;
    tick();
    win_len = '0; enable = 1;
    tick();
    for (int i = 0; i < 6; i++) begin
      smile = (i % 2 == 0);
      tick();
      checks++; if (report_valid_out !== 1'b1 || report_data_out !== CNT_W'(i % 2 == 0))
        $display("FAIL winlen0 i=%0d: got %0d/%b expected %0d/1", i, report_data_out, report_valid_out, (i % 2 == 0)); else passed++;
    end
    smile = 0; enable = 0;
    tick();
  endtask

  task automatic test_async_reset();
    smile = 0; ready = 0; win_len = 16'd5; enable = 1;
    tick();
    for (int i = 0; i < 5; i++) begin smile = (i == 0); tick(); end
    for (int i = 0; i < 5; i++) begin smile = (i == 1); tick(); end
    for (int i = 0; i < 2; i++) begin smile = (i == 0); tick(); end
    checks++; if (report_valid_out !== 1'b1 || report_overrun_out !== 1'b1 || report_data_out !== 4'd1)
      $display("FAIL arst_pre: got %0d/%b/%b expected 1/1/1", report_data_out, report_valid_out, report_overrun_out); else passed++;
    #2;
    rst = 1;
    #1;
    checks++; if (report_data_out !== '0 || report_valid_out !== 1'b0 || report_overrun_out !== 1'b0)
      $display("FAIL arst_async: got %0d/%b/%b expected 0/0/0", report_data_out, report_valid_out, report_overrun_out); else passed++;
    smile = 0;
    @(posedge clk);
    #1;
    rst = 0;
    m_reset();
    ready = 1; enable = 1; win_len = 16'd5;
    tick();
    for (int i = 0; i < 5; i++) begin smile = (i == 2); tick(); end
    checks++; if (report_data_out !== 4'd1 || report_valid_out !== 1'b1)
      $display("FAIL arst_post: got %0d/%b expected 1/1", report_data_out, report_valid_out); else passed++;
    smile = 0; enable = 0;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      smile   = ($urandom_range(0, 2) == 0);
      enable  = ($urandom_range(0, 24) != 0);
      ready   = ($urandom_range(0, 1) == 1);
      clr     = ($urandom_range(0, 15) == 0);
      win_len = WIN_W'($urandom_range(0, 6));
      tick();
      checks++; if (report_data_out !== CNT_W'(m_data))
        $display("FAIL rand_data n=%0d: got %0d expected %0d", n, report_data_out, m_data); else passed++;
      checks++; if (report_valid_out !== m_valid)
        $display("FAIL rand_valid n=%0d: got %b expected %b", n, report_valid_out, m_valid); else passed++;
      checks++; if (report_overrun_out !== m_ovr)
        $display("FAIL rand_overrun n=%0d: got %b expected %b", n, report_overrun_out, m_ovr); else passed++;
    end
    clr = 0;
  endtask

  initial begin
    m_reset();
    test_reset();
    test_basic();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
